// File: rtl/cpx_accumulate.sv
// -----------------------------------------------------------------------------
// cpx_accumulate
//   Complex integrate-and-dump stage. Sums LENGTH accepted complex samples per
//   frame in separate I and Q accumulators and emits one full-precision sum per
//   frame, flagged by a one-cycle s_axis_tvalid pulse. The outputs hold their
//   value until the next completed frame.
//
// Ports
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous reset, active-low
//   m_axis_tvalid  in   1           i_in/q_in valid this cycle
//   i_in           in   I_BITS      signed I sample
//   q_in           in   Q_BITS      signed Q sample
//   clear          in   1           synchronous frame abort, active-high
//   s_axis_tvalid  out  1           one-cycle pulse: new frame sum on i_out/q_out
//   i_out          out  I_OUT_BITS  signed I frame sum
//   q_out          out  Q_OUT_BITS  signed Q frame sum
//   frame_active   out  1           high while a partial frame is held
// -----------------------------------------------------------------------------
module cpx_accumulate #(
  parameter  int I_BITS     = 24,
  parameter  int Q_BITS     = 24,
  parameter  int LENGTH     = 16,
  localparam int CNT_BITS   = $clog2(LENGTH),
  localparam int I_OUT_BITS = I_BITS + CNT_BITS,
  localparam int Q_OUT_BITS = Q_BITS + CNT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_axis_tvalid,
  input  logic [I_BITS-1:0]     i_in,
  input  logic [Q_BITS-1:0]     q_in,
  input  logic                  clear,
  output logic                  s_axis_tvalid,
  output logic [I_OUT_BITS-1:0] i_out,
  output logic [Q_OUT_BITS-1:0] q_out,
  output logic                  frame_active
);

  localparam logic [CNT_BITS-1:0] C_CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] C_CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] C_CNT_LAST = CNT_BITS'(LENGTH - 1);

  logic [CNT_BITS-1:0]   r_cnt;
  logic [I_OUT_BITS-1:0] r_acc_i;
  logic [Q_OUT_BITS-1:0] r_acc_q;
  logic [I_OUT_BITS-1:0] r_i_out;
  logic [Q_OUT_BITS-1:0] r_q_out;
  logic                  r_valid;
  logic                  r_frame_active;

  logic [CNT_BITS-1:0]   w_cnt_nxt;
  logic [I_OUT_BITS-1:0] w_acc_i_nxt;
  logic [Q_OUT_BITS-1:0] w_acc_q_nxt;
  logic [I_OUT_BITS-1:0] w_i_out_nxt;
  logic [Q_OUT_BITS-1:0] w_q_out_nxt;
  logic                  w_valid_nxt;
  logic [I_OUT_BITS-1:0] w_ext_i;
  logic [Q_OUT_BITS-1:0] w_ext_q;

  // Sign-extend the samples to full output width; the extra CNT_BITS of
  // headroom make overflow impossible for LENGTH samples.
  assign w_ext_i = {{CNT_BITS{i_in[I_BITS-1]}}, i_in};
  assign w_ext_q = {{CNT_BITS{q_in[Q_BITS-1]}}, q_in};

  // Next-state logic: clear wins over any coincident sample, sample 0 loads
  // the accumulators, the last sample dumps acc+sample to the outputs.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_acc_i_nxt = r_acc_i;
    w_acc_q_nxt = r_acc_q;
    w_i_out_nxt = r_i_out;
    w_q_out_nxt = r_q_out;
    w_valid_nxt = 1'b0;
    if (clear) begin
      w_cnt_nxt   = C_CNT_ZERO;
      w_acc_i_nxt = {I_OUT_BITS{1'b0}};
      w_acc_q_nxt = {Q_OUT_BITS{1'b0}};
    end else if (m_axis_tvalid) begin
      if (r_cnt == C_CNT_ZERO) begin
        w_acc_i_nxt = w_ext_i;
        w_acc_q_nxt = w_ext_q;
        w_cnt_nxt   = C_CNT_ONE;
      end else if (r_cnt == C_CNT_LAST) begin
        w_i_out_nxt = r_acc_i + w_ext_i;
        w_q_out_nxt = r_acc_q + w_ext_q;
        w_valid_nxt = 1'b1;
        w_cnt_nxt   = C_CNT_ZERO;
      end else begin
        w_acc_i_nxt = r_acc_i + w_ext_i;
        w_acc_q_nxt = r_acc_q + w_ext_q;
        w_cnt_nxt   = r_cnt + C_CNT_ONE;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State and output registers; frame_active tracks the post-edge counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= C_CNT_ZERO;
      r_acc_i        <= {I_OUT_BITS{1'b0}};
      r_acc_q        <= {Q_OUT_BITS{1'b0}};
      r_i_out        <= {I_OUT_BITS{1'b0}};
      r_q_out        <= {Q_OUT_BITS{1'b0}};
      r_valid        <= 1'b0;
      r_frame_active <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_acc_i        <= w_acc_i_nxt;
      r_acc_q        <= w_acc_q_nxt;
      r_i_out        <= w_i_out_nxt;
      r_q_out        <= w_q_out_nxt;
      r_valid        <= w_valid_nxt;
      r_frame_active <= (w_cnt_nxt != C_CNT_ZERO);
    end
  end

  assign s_axis_tvalid = r_valid;
  assign i_out         = r_i_out;
  assign q_out         = r_q_out;
  assign frame_active  = r_frame_active;

endmodule

// File: tb/tb_cpx_accumulate.sv
// -----------------------------------------------------------------------------
// tb_cpx_accumulate
//   Self-checking bench for cpx_accumulate. Instance A: LENGTH=4, 8-bit I/Q.
//   Instance B: LENGTH=16, 8-bit I/Q. Expected frame sums are queued as the
//   stimulus is driven and popped by a monitor on every s_axis_tvalid pulse.
// -----------------------------------------------------------------------------
module tb_cpx_accumulate;

  typedef struct {
    int i;
    int q;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       a_v, a_c;
  logic [7:0] a_i, a_q;
  logic       a_vld, a_act;
  logic [9:0] a_i_out, a_q_out;

  logic       b_v, b_c;
  logic [7:0] b_i, b_q;
  logic       b_vld, b_act;
  logic [11:0] b_i_out, b_q_out;

  int   n_vec;
  int   n_err;
  exp_t qa[$];
  exp_t qb[$];

  cpx_accumulate #(.I_BITS(8), .Q_BITS(8), .LENGTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .m_axis_tvalid(a_v), .i_in(a_i), .q_in(a_q),
    .clear(a_c), .s_axis_tvalid(a_vld), .i_out(a_i_out), .q_out(a_q_out),
    .frame_active(a_act)
  );

  cpx_accumulate #(.I_BITS(8), .Q_BITS(8), .LENGTH(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .m_axis_tvalid(b_v), .i_in(b_i), .q_in(b_q),
    .clear(b_c), .s_axis_tvalid(b_vld), .i_out(b_i_out), .q_out(b_q_out),
    .frame_active(b_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor for instance A: every pulse must match the queue head.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n === 1'b1 && a_vld === 1'b1) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL sb_a_unexpected: pulse with i_out=%0d q_out=%0d, none expected",
                 $signed(a_i_out), $signed(a_q_out));
      end else begin
        e = qa.pop_front();
        if (int'($signed(a_i_out)) !== e.i || int'($signed(a_q_out)) !== e.q) begin
          n_err++;
          $display("FAIL sb_a_sum: got (%0d,%0d) expected (%0d,%0d)",
                   $signed(a_i_out), $signed(a_q_out), e.i, e.q);
        end
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n === 1'b1 && b_vld === 1'b1) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL sb_b_unexpected: pulse with i_out=%0d q_out=%0d, none expected",
                 $signed(b_i_out), $signed(b_q_out));
      end else begin
        e = qb.pop_front();
        if (int'($signed(b_i_out)) !== e.i || int'($signed(b_q_out)) !== e.q) begin
          n_err++;
          $display("FAIL sb_b_sum: got (%0d,%0d) expected (%0d,%0d)",
                   $signed(b_i_out), $signed(b_q_out), e.i, e.q);
        end
      end
    end
  end

  task automatic push_a(input int i, input int q);
    exp_t e;
    e.i = i;
    e.q = q;
    qa.push_back(e);
  endtask

  // Present one cycle of stimulus on A, return #1 after the accepting edge.
  task automatic step_a(input logic v, input int i, input int q, input logic c);
    a_v = v; a_i = i[7:0]; a_q = q[7:0]; a_c = c;
    @(posedge clk); #1;
    a_v = 1'b0; a_c = 1'b0;
  endtask

  task automatic step_b(input logic v, input int i, input int q, input logic c);
    b_v = v; b_i = i[7:0]; b_q = q[7:0]; b_c = c;
    @(posedge clk); #1;
    b_v = 1'b0; b_c = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_v = 1'b0; a_c = 1'b0; a_i = 8'd0; a_q = 8'd0;
    b_v = 1'b0; b_c = 1'b0; b_i = 8'd0; b_q = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({a_vld, a_act, a_i_out, a_q_out} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_a: vld=%b act=%b i=%0d q=%0d, required all 0",
               a_vld, a_act, a_i_out, a_q_out);
    end
    n_vec++;
    if ({b_vld, b_act, b_i_out, b_q_out} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_b: vld=%b act=%b i=%0d q=%0d, required all 0",
               b_vld, b_act, b_i_out, b_q_out);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    push_a(10, -10);
    for (int k = 1; k <= 4; k++) begin
      step_a(1'b1, k, -k, 1'b0);
      n_vec++;
      if (a_vld !== (k == 4)) begin
        n_err++;
        $display("FAIL basic_pulse_timing: after sample %0d vld=%b required %b", k, a_vld, (k == 4));
      end
    end
    step_a(1'b0, 0, 0, 1'b0);
    n_vec++;
    if (a_vld !== 1'b0 || int'($signed(a_i_out)) !== 10) begin
      n_err++;
      $display("FAIL basic_hold: vld=%b i_out=%0d, required vld=0 i_out=10", a_vld, $signed(a_i_out));
    end
  endtask

  task automatic test_wide();
    exp_t e;
    e.i = -2048;
    e.q = 2032;
    qb.push_back(e);
    for (int k = 0; k < 16; k++) step_b(1'b1, -128, 127, 1'b0);
    n_vec++;
    if (b_vld !== 1'b1 || b_act !== 1'b0) begin
      n_err++;
      $display("FAIL wide_pulse: vld=%b act=%b, required vld=1 act=0", b_vld, b_act);
    end
    step_b(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_gap();
    push_a(26, -26);
    step_a(1'b1, 5, -5, 1'b0);
    step_a(1'b1, 6, -6, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step_a(1'b0, 99, 99, 1'b0);
      n_vec++;
      if (a_act !== 1'b1 || a_vld !== 1'b0) begin
        n_err++;
        $display("FAIL gap_active: gap cycle %0d act=%b vld=%b, required act=1 vld=0", g, a_act, a_vld);
      end
    end
    step_a(1'b1, 7, -7, 1'b0);
    step_a(1'b1, 8, -8, 1'b0);
    n_vec++;
    if (a_vld !== 1'b1) begin
      n_err++;
      $display("FAIL gap_pulse: vld=%b required 1", a_vld);
    end
    step_a(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_clear();
    step_a(1'b1, 1, 1, 1'b0);
    step_a(1'b1, 2, 2, 1'b0);
    step_a(1'b1, 99, 99, 1'b1);      // clear with a coincident (dropped) sample
    n_vec++;
    if (a_act !== 1'b0) begin
      n_err++;
      $display("FAIL clear_abort: act=%b required 0", a_act);
    end
    push_a(100, -100);
    step_a(1'b1, 10, -10, 1'b0);
    step_a(1'b1, 20, -20, 1'b0);
    step_a(1'b1, 30, -30, 1'b0);
    step_a(1'b1, 40, -40, 1'b0);
    step_a(1'b0, 0, 0, 1'b0);
    // Clear on the dump cycle suppresses the pulse and keeps the old sum.
    step_a(1'b1, 1, 1, 1'b0);
    step_a(1'b1, 2, 2, 1'b0);
    step_a(1'b1, 3, 3, 1'b0);
    step_a(1'b1, 4, 4, 1'b1);
    n_vec++;
    if (a_vld !== 1'b0 || a_act !== 1'b0 || int'($signed(a_i_out)) !== 100) begin
      n_err++;
      $display("FAIL clear_on_dump: vld=%b act=%b i_out=%0d, required 0 0 100",
               a_vld, a_act, $signed(a_i_out));
    end
    step_a(1'b0, 0, 0, 1'b1);        // clear while idle is a no-op
    n_vec++;
    if (a_act !== 1'b0 || a_vld !== 1'b0 || int'($signed(a_q_out)) !== -100) begin
      n_err++;
      $display("FAIL clear_idle: act=%b vld=%b q_out=%0d, required 0 0 -100",
               a_act, a_vld, $signed(a_q_out));
    end
  endtask

  task automatic test_back_to_back();
    push_a(10, 0);
    push_a(26, 0);
    push_a(42, 0);
    for (int k = 1; k <= 12; k++) begin
      step_a(1'b1, k, 0, 1'b0);
      n_vec++;
      if (a_vld !== ((k % 4) == 0)) begin
        n_err++;
        $display("FAIL b2b_pulse: after sample %0d vld=%b required %b", k, a_vld, ((k % 4) == 0));
      end
    end
    step_a(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    step_a(1'b1, 3, 3, 1'b0);
    step_a(1'b1, 3, 3, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_vld, a_act, a_i_out, a_q_out} !== 22'd0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b act=%b i=%0d q=%0d, required all 0",
               a_vld, a_act, a_i_out, a_q_out);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    push_a(4, 4);
    for (int k = 0; k < 4; k++) step_a(1'b1, 1, 1, 1'b0);
    n_vec++;
    if (a_vld !== 1'b1) begin
      n_err++;
      $display("FAIL async_restart: vld=%b required 1", a_vld);
    end
    repeat (3) step_a(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_wide();
    test_gap();
    test_clear();
    test_back_to_back();
    test_async_reset();
    n_vec++;
    if (qa.size() !== 0 || qb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d/%0d sums never produced, required 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
